// File: rtl/cache_req_arb_pkg.sv
// Shared types and the round-robin helper used by the cache request arbiter.
package cache_arb_pkg;

  // Widest requester vector the round-robin helper handles.
  localparam int RR_MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } arb_state_t;

  // First set bit of mask at or after ptr, wrapping at n; one-hot result, zero if mask is empty.
  function automatic logic [RR_MAX_REQ-1:0] rr_onehot(input logic [RR_MAX_REQ-1:0] mask,
                                                     input int unsigned ptr,
                                                     input int unsigned n);
    logic [RR_MAX_REQ-1:0] grant;
    logic                  found;
    int unsigned           idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && mask[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/cache_req_arb_if.sv
// Requester-side and main-FSM-side signals of the cache request arbiter.
interface cache_req_arb_if #(
  parameter int N_REQ = 2,
  parameter int PKT_W = 64,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*PKT_W-1:0] req_pkt_i;
  logic [N_REQ-1:0]       req_urgent_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   pkt_valid_o;
  logic [PKT_W-1:0]       pkt_data_o;
  logic                   pkt_ready_i;
  logic                   done_i;
  logic                   rsp_valid_o;
  logic [IDW-1:0]         rsp_id_o;
  logic                   busy_o;
  logic                   err_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_pkt_i, req_urgent_i, pkt_ready_i, done_i,
    output req_ready_o, pkt_valid_o, pkt_data_o, rsp_valid_o, rsp_id_o, busy_o, err_o
  );

  // Requesters plus main FSM side.
  modport master (
    output req_valid_i, req_pkt_i, req_urgent_i, pkt_ready_i, done_i,
    input  req_ready_o, pkt_valid_o, pkt_data_o, rsp_valid_o, rsp_id_o, busy_o, err_o
  );

endinterface

// File: rtl/cache_req_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant, encoded id and any-request flag.
module cache_rr_pick
  import cache_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic [N_REQ-1:0] mask_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDW-1:0]   id_o,
  output logic             any_o
);

  logic [RR_MAX_REQ-1:0] mask_ext;

  // Widen the mask to the helper width and pick the first requester at or after ptr_i.
  always_comb begin
    mask_ext                = '0;
    mask_ext[N_REQ-1:0]     = mask_i;
    grant_o                 = N_REQ'(rr_onehot(mask_ext, 32'(ptr_i), N_REQ));
  end

  // Encode the one-hot grant into a requester id.
  always_comb begin
    id_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_o[k]) id_o = IDW'(k);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/cache_req_arb.sv
// Arbitrates N requesters onto the cache main FSM packet port, one transaction at a time.
// Priority: starved requesters, then urgent, then plain; round-robin within each class.
module cache_req_arb
  import cache_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int PKT_W      = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic            aclk_i,
  input  logic            arstn_i,
  cache_req_arb_if.slave  bus
);

  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AGE_W = $clog2(STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);
  localparam logic [IDW-1:0]   ID_LAST = IDW'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AGE_W-1:0] age_q [N_REQ];
  logic [AGE_W-1:0] age_d [N_REQ];
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] starved_mask, urgent_mask, plain_mask;
  logic [N_REQ-1:0] starved_grant, urgent_grant, plain_grant;
  logic [IDW-1:0]   starved_id, urgent_id, plain_id;
  logic             starved_any, urgent_any, plain_any;
  logic [N_REQ-1:0] win_grant;
  logic [IDW-1:0]   win_id;
  logic [N_REQ-1:0] ready;
  logic             accept, complete;

  // Class masks; a starved requester must still be asserting valid to be picked.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      starved_mask[k] = bus.req_valid_i[k] && (age_q[k] == AGE_MAX);
    end
    urgent_mask = bus.req_valid_i & bus.req_urgent_i;
    plain_mask  = bus.req_valid_i;
  end

  cache_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick_starved (
    .mask_i  (starved_mask),
    .ptr_i   (rr_ptr_q),
    .grant_o (starved_grant),
    .id_o    (starved_id),
    .any_o   (starved_any)
  );

  cache_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick_urgent (
    .mask_i  (urgent_mask),
    .ptr_i   (rr_ptr_q),
    .grant_o (urgent_grant),
    .id_o    (urgent_id),
    .any_o   (urgent_any)
  );

  cache_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick_plain (
    .mask_i  (plain_mask),
    .ptr_i   (rr_ptr_q),
    .grant_o (plain_grant),
    .id_o    (plain_id),
    .any_o   (plain_any)
  );

  // Highest non-empty class wins.
  always_comb begin
    win_grant = plain_grant;
    win_id    = plain_id;
    if (starved_any) begin
      win_grant = starved_grant;
      win_id    = starved_id;
    end else if (urgent_any) begin
      win_grant = urgent_grant;
      win_id    = urgent_id;
    end
  end

  // FSM next state, accept/complete strobes and sticky error.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (plain_any) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
        if (bus.done_i) err_d = 1'b1;
      end
      ISSUE: begin
        if (bus.pkt_ready_i) begin
          if (bus.done_i) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.done_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE) ? win_grant : '0;

  // Packet/id capture on accept, response and round-robin pointer update on completion.
  always_comb begin
    pkt_d       = pkt_q;
    id_d        = id_q;
    rsp_valid_d = complete;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      pkt_d = bus.req_pkt_i[int'(win_id)*PKT_W +: PKT_W];
      id_d  = win_id;
    end
    if (complete) begin
      rsp_id_d = id_q;
      rr_ptr_d = (id_q == ID_LAST) ? '0 : id_q + IDW'(1);
    end
  end

  // Per-requester waiting age, saturating; cleared on accept or when valid drops.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      age_d[k] = age_q[k];
      if (!bus.req_valid_i[k] || ready[k]) begin
        age_d[k] = '0;
      end else if (age_q[k] != AGE_MAX) begin
        age_d[k] = age_q[k] + AGE_W'(1);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge aclk_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < N_REQ; k++) age_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      for (int k = 0; k < N_REQ; k++) age_q[k] <= age_d[k];
    end
  end

  // Captured packet and ids; cleared by reset so outputs read zero afterwards.
  always_ff @(posedge aclk_i) begin
    if (!arstn_i) begin
      pkt_q    <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
    end else begin
      pkt_q    <= pkt_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.pkt_valid_o = (state_q == ISSUE);
  assign bus.pkt_data_o  = pkt_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_cache_req_arb.sv
// Directed bench for cache_req_arb: round-robin, urgency, starvation, back-pressure,
// same-cycle completion, reset mid-transaction and the done-in-idle error flag.
module tb_cache_req_arb;

  localparam int N_REQ = 2;
  localparam int PKT_W = 64;
  localparam int IDW   = 1;
  localparam logic [63:0] P0 = 64'hC0FF_EE00_0000_0A0A;
  localparam logic [63:0] P1 = 64'h1234_5678_9ABC_DEF1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  cache_req_arb_if #(.N_REQ(N_REQ), .PKT_W(PKT_W), .IDW(IDW)) bus ();

  cache_req_arb #(.N_REQ(N_REQ), .PKT_W(PKT_W), .STARVE_MAX(3)) dut (
    .aclk_i  (clk),
    .arstn_i (rstn),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called 1ns after a negedge with the winner already presented in IDLE.
  task automatic run_txn(input logic [1:0] exp_rdy, input logic exp_id, input logic [63:0] exp_data);
    #1;
    chk("grant", 64'(bus.req_ready_o), 64'(exp_rdy));
    @(negedge clk); bus.done_i = 1'b0; #1;
    chk("issue_valid", 64'(bus.pkt_valid_o), 64'd1);
    chk("issue_data", bus.pkt_data_o, exp_data);
    @(negedge clk); bus.done_i = 1'b1; #1;
    chk("wait_valid", 64'(bus.pkt_valid_o), 64'd0);
    chk("wait_busy", 64'(bus.busy_o), 64'd1);
    @(negedge clk); bus.done_i = 1'b0; #1;
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("rsp_id", 64'(bus.rsp_id_o), 64'(exp_id));
  endtask

  initial begin
    bus.req_valid_i  = '0;
    bus.req_urgent_i = '0;
    bus.req_pkt_i    = {P1, P0};
    bus.pkt_ready_i  = 1'b0;
    bus.done_i       = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_pkt_valid", 64'(bus.pkt_valid_o), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);

    // Round-robin with both requesters always valid
    @(negedge clk);
    rstn = 1'b1;
    bus.req_valid_i = 2'b11;
    bus.pkt_ready_i = 1'b1;
    run_txn(2'b01, 1'b0, P0);
    run_txn(2'b10, 1'b1, P1);
    run_txn(2'b01, 1'b0, P0);
    run_txn(2'b10, 1'b1, P1);

    // Idle cycle with no requests clears ages
    bus.req_valid_i = 2'b00; #1;
    chk("no_req_ready", 64'(bus.req_ready_o), 64'd0);

    // Urgent req1 beats req0 with rr_ptr at 0
    @(negedge clk);
    bus.req_valid_i  = 2'b11;
    bus.req_urgent_i = 2'b10;
    run_txn(2'b10, 1'b1, P1);

    // req0 has aged to 3 during that transaction and now overrides urgent req1
    run_txn(2'b01, 1'b0, P0);

    // Back-pressure: pkt_ready low for several ISSUE cycles, done ignored there
    bus.req_valid_i  = 2'b10;
    bus.req_urgent_i = 2'b00;
    bus.pkt_ready_i  = 1'b0; #1;
    chk("bp_grant", 64'(bus.req_ready_o), 64'b10);
    @(negedge clk); #1;
    chk("bp_issue", 64'(bus.pkt_valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.done_i = (i == 2); #1;
      chk("bp_valid", 64'(bus.pkt_valid_o), 64'd1);
      chk("bp_data", bus.pkt_data_o, P1);
      chk("bp_no_ready", 64'(bus.req_ready_o), 64'd0);
    end
    bus.pkt_ready_i = 1'b1;
    @(negedge clk); bus.done_i = 1'b1; #1;
    chk("bp_wait", 64'(bus.pkt_valid_o), 64'd0);
    @(negedge clk); bus.done_i = 1'b0; #1;
    chk("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("bp_rsp_id", 64'(bus.rsp_id_o), 64'd1);

    // Same-cycle pkt_ready and done: straight back to IDLE
    bus.req_valid_i = 2'b01; #1;
    chk("sc_grant", 64'(bus.req_ready_o), 64'b01);
    @(negedge clk); bus.done_i = 1'b1; #1;
    chk("sc_issue", 64'(bus.pkt_valid_o), 64'd1);
    chk("sc_data", bus.pkt_data_o, P0);
    @(negedge clk);
    bus.done_i      = 1'b0;
    bus.req_valid_i = 2'b10; #1;
    chk("sc_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("sc_rsp_id", 64'(bus.rsp_id_o), 64'd0);
    chk("sc_not_busy", 64'(bus.busy_o), 64'd0);
    chk("sc_next_grant", 64'(bus.req_ready_o), 64'b10);
    chk("sc_err_clear", 64'(bus.err_o), 64'd0);

    // Reset while in WAIT_DONE, then a stray done in IDLE
    @(negedge clk);
    bus.req_valid_i = 2'b00; #1;
    chk("r6_issue", 64'(bus.pkt_valid_o), 64'd1);
    @(negedge clk); #1;
    chk("r6_wait_busy", 64'(bus.busy_o), 64'd1);
    rstn = 1'b0;
    @(negedge clk); #1;
    chk("r6_pkt_valid", 64'(bus.pkt_valid_o), 64'd0);
    chk("r6_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("r6_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("r6_busy", 64'(bus.busy_o), 64'd0);
    chk("r6_err", 64'(bus.err_o), 64'd0);
    chk("r6_rsp_id", 64'(bus.rsp_id_o), 64'd0);
    chk("r6_pkt_data", bus.pkt_data_o, 64'd0);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("r6_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    bus.done_i = 1'b1;
    @(negedge clk); bus.done_i = 1'b0; #1;
    chk("err_set", 64'(bus.err_o), 64'd1);
    chk("err_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    chk("err_idle", 64'(bus.busy_o), 64'd0);
    @(negedge clk); #1;
    chk("err_sticky", 64'(bus.err_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
